reg_file_8x16_onehot: RTL and testbench

- Eight-entry by 16-bit general-purpose register file for the 16-bit RISC datapath.
- Sits directly downstream of the 3-to-8 write-select decoder and consumes its one-hot output as the write-load vector.
- Provides two registered read ports, S and R, that feed the ALU operand buses.
- Adds one-hot integrity checking, read-during-write bypass and per-register written-status tracking.

---
 rtl/reg_file_8x16_onehot.sv | 81 ++++++++
 tb/tb_reg_file_8x16_onehot.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_8x16_onehot.sv
// 8 x DATA_W register file written through a one-hot load vector, with two
// registered read ports, write-first bypass, sticky multi-hot error and per-entry written flags.
module reg_file_8x16_onehot #(
  parameter int unsigned         DATA_W  = 16,
  parameter logic [DATA_W-1:0]   RST_VAL = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        W_Sel,
  input  logic [DATA_W-1:0] W_Data,
  input  logic [2:0]        S_Addr,
  input  logic [2:0]        R_Addr,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] S_out,
  output logic [DATA_W-1:0] R_out,
  output logic              rd_valid,
  output logic              wr_err,
  output logic [7:0]        vld
);

  logic [DATA_W-1:0] regs [8];
  logic [7:0]        sel_m1;
  logic              sel_any;
  logic              sel_onehot;
  logic              sel_multi;
  logic              s_byp;
  logic              r_byp;

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  always_comb begin
    sel_m1     = W_Sel - 8'd1;
    sel_any    = |W_Sel;
    sel_onehot = sel_any & ~(|(W_Sel & sel_m1));
    sel_multi  = sel_any & ~sel_onehot;
    s_byp      = sel_onehot & W_Sel[S_Addr];
    r_byp      = sel_onehot & W_Sel[R_Addr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        regs[i] <= RST_VAL;
      end
      vld <= '0;
    end else if (sel_onehot) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (W_Sel[i]) begin
          regs[i] <= W_Data;
          vld[i]  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      S_out    <= '0;
      R_out    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        S_out <= s_byp ? W_Data : regs[S_Addr];
        R_out <= r_byp ? W_Data : regs[R_Addr];
      end
    end
  end

  // A multi-hot select in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_err <= 1'b0;
    end else if (sel_multi) begin
      wr_err <= 1'b1;
    end else if (err_clr) begin
      wr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_8x16_onehot.sv
// Directed bench for reg_file_8x16_onehot: a behavioural model checked every cycle,
// plus literal expectations at key points of the sequence.
module tb_reg_file_8x16_onehot;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  W_Sel;
  logic [15:0] W_Data;
  logic [2:0]  S_Addr;
  logic [2:0]  R_Addr;
  logic        rd_en;
  logic        err_clr;
  logic [15:0] S_out;
  logic [15:0] R_out;
  logic        rd_valid;
  logic        wr_err;
  logic [7:0]  vld;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [15:0] m_mem [8];
  logic [15:0] m_s;
  logic [15:0] m_r;
  logic        m_valid;
  logic        m_err;
  logic [7:0]  m_vld;

  reg_file_8x16_onehot #(.DATA_W(16), .RST_VAL(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .W_Sel(W_Sel), .W_Data(W_Data),
    .S_Addr(S_Addr), .R_Addr(R_Addr), .rd_en(rd_en), .err_clr(err_clr),
    .S_out(S_out), .R_out(R_out), .rd_valid(rd_valid), .wr_err(wr_err), .vld(vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count set bits of the select, look up the written index, apply write-first.
  always @(posedge clk) begin
    int n;
    n = $countones(W_Sel);
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
      m_s = 0; m_r = 0; m_valid = 0; m_err = 0; m_vld = 0;
    end else begin
      m_valid = rd_en;
      if (rd_en) begin
        m_s = (n == 1 && W_Sel[S_Addr]) ? W_Data : m_mem[S_Addr];
        m_r = (n == 1 && W_Sel[R_Addr]) ? W_Data : m_mem[R_Addr];
      end
      if (n == 1) begin
        for (int i = 0; i < 8; i++) begin
          if (W_Sel == (8'd1 << i)) begin
            m_mem[i] = W_Data;
            m_vld[i] = 1'b1;
          end
        end
      end
      if (n > 1) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("S_out", S_out, m_s);
      chk("R_out", R_out, m_r);
      chk("rd_valid", {15'd0, rd_valid}, {15'd0, m_valid});
      chk("wr_err", {15'd0, wr_err}, {15'd0, m_err});
      chk("vld", {8'd0, vld}, {8'd0, m_vld});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 0; W_Sel = 8'h01; W_Data = 16'hFFFF; rd_en = 1;
    S_Addr = 0; R_Addr = 0; err_clr = 0;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst S_out", S_out, 16'h0000);
    chk("rst R_out", R_out, 16'h0000);
    chk("rst rd_valid", {15'd0, rd_valid}, 16'h0000);
    chk("rst vld", {8'd0, vld}, 16'h0000);
    chk("rst wr_err", {15'd0, wr_err}, 16'h0000);

    reset_n = 1; W_Sel = 0; rd_en = 0;
    cyc();
    chk("post-rst rd_valid", {15'd0, rd_valid}, 16'h0000);
    rd_en = 1; S_Addr = 0; R_Addr = 0;
    cyc();
    chk("read0 S_out", S_out, 16'h0000);
    chk("read0 rd_valid", {15'd0, rd_valid}, 16'h0001);

    // write then read
    rd_en = 0; W_Sel = 8'h08; W_Data = 16'h1234;
    cyc();
    W_Sel = 0; rd_en = 1; S_Addr = 3; R_Addr = 0;
    cyc();
    chk("wr S_out", S_out, 16'h1234);
    chk("wr R_out", R_out, 16'h0000);
    chk("wr vld", {8'd0, vld}, 16'h0008);

    // bypass on both ports
    W_Sel = 8'h20; W_Data = 16'hBEEF; S_Addr = 5; R_Addr = 5;
    cyc();
    chk("byp S_out", S_out, 16'hBEEF);
    chk("byp R_out", R_out, 16'hBEEF);
    W_Sel = 0; S_Addr = 5; R_Addr = 3;
    cyc();
    chk("after byp S_out", S_out, 16'hBEEF);
    chk("after byp R_out", R_out, 16'h1234);

    // multi-hot write is rejected and never bypasses
    rd_en = 0; W_Sel = 8'h02; W_Data = 16'h00AA;
    cyc();
    W_Sel = 8'h03; W_Data = 16'h5555;
    cyc();
    chk("multi wr_err", {15'd0, wr_err}, 16'h0001);
    chk("multi vld", {8'd0, vld}, 16'h002A);
    W_Sel = 8'h03; W_Data = 16'h7777; rd_en = 1; S_Addr = 1; R_Addr = 0;
    cyc();
    chk("multi nobyp S_out", S_out, 16'h00AA);
    chk("multi nobyp R_out", R_out, 16'h0000);

    // err_clr collides with multi-hot, then clears
    rd_en = 0; err_clr = 1; W_Sel = 8'h81; W_Data = 16'h9999;
    cyc();
    chk("clr collide wr_err", {15'd0, wr_err}, 16'h0001);
    W_Sel = 0;
    cyc();
    chk("clr wr_err", {15'd0, wr_err}, 16'h0000);
    err_clr = 0;
    cyc();
    chk("hold S_out", S_out, 16'h00AA);
    chk("hold rd_valid", {15'd0, rd_valid}, 16'h0000);

    // back-to-back reads while filling every entry
    for (int i = 0; i < 8; i++) begin
      W_Sel = 8'd1 << i; W_Data = 16'hA000 + 16'(i); rd_en = 1;
      S_Addr = 3'(i); R_Addr = 3'(7 - i);
      cyc();
    end
    chk("b2b S_out", S_out, 16'hA007);
    chk("b2b R_out", R_out, 16'hA000);
    chk("b2b vld", {8'd0, vld}, 16'h00FF);

    // reset in the cycle after a read
    W_Sel = 8'h06; S_Addr = 2; R_Addr = 6;
    cyc();
    chk("pre-rst rd_valid", {15'd0, rd_valid}, 16'h0001);
    reset_n = 0; W_Sel = 8'h10; W_Data = 16'h4321;
    cyc();
    chk("midrst rd_valid", {15'd0, rd_valid}, 16'h0000);
    chk("midrst S_out", S_out, 16'h0000);
    chk("midrst wr_err", {15'd0, wr_err}, 16'h0000);
    reset_n = 1; W_Sel = 0; rd_en = 1;
    for (int i = 0; i < 8; i++) begin
      S_Addr = 3'(i); R_Addr = 3'(7 - i);
      cyc();
      chk("rst val S", S_out, 16'h0000);
    end
    rd_en = 0;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
